d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 44 ++++
 tb/tb_d_flip_flop.sv | 133 +++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// D-type storage register with synchronous active-high clear to a parameterised value.
// Each bit is its own cell, so every bit of q follows the same clear/load rule on its own.

module d_flip_flop_bit #(
    parameter logic CLEAR_BIT = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clear) q <= CLEAR_BIT;
        else       q <= d;
    end

endmodule

module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_flip_flop_bit #(
            .CLEAR_BIT (CLEAR_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .clear (clear),
            .d     (d[i]),
            .q     (q[i])
        );
    end

    assign qn = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: a 1-bit default instance and an 8-bit instance clearing to 8'hA5,
// with expected outputs queued at drive time and popped after each rising edge.
`timescale 1ns/100ps

module tb_d_flip_flop;

    typedef struct packed {
        logic       q1;
        logic       qn1;
        logic [7:0] q8;
        logic [7:0] qn8;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear;
    logic       d1;
    logic [7:0] d8;
    logic       q1, qn1;
    logic [7:0] q8, qn8;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t last;
    bit   last_vld = 1'b0;

    always #1 clk = ~clk;

    d_flip_flop u_dut1 (
        .clk   (clk),
        .clear (clear),
        .d     (d1),
        .q     (q1),
        .qn    (qn1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .CLEAR_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .clear (clear),
        .d     (d8),
        .q     (q8),
        .qn    (qn8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs from mid-cycle, check q held between edges,
    // then pop the queued expectation after the next rising edge.
    task automatic cycle(input logic c, input logic dv1, input logic [7:0] dv8, input bit glitch);
        exp_t e, got;
        clear = c;
        d1    = dv1;
        d8    = dv8;
        e.q1  = c ? 1'b0  : dv1;
        e.qn1 = ~e.q1;
        e.q8  = c ? 8'hA5 : dv8;
        e.qn8 = ~e.q8;
        sb.push_back(e);
        if (glitch) begin
            #0.3 d1 = ~dv1; d8 = ~dv8;
            #0.3;
            if (last_vld) begin
                chk("hold_q1", {31'b0, q1}, {31'b0, last.q1});
                chk("hold_q8", {24'b0, q8}, {24'b0, last.q8});
            end
            #0.3 d1 = dv1; d8 = dv8;
        end else begin
            #0.5;
            if (last_vld) begin
                chk("hold_q1", {31'b0, q1}, {31'b0, last.q1});
                chk("hold_q8", {24'b0, q8}, {24'b0, last.q8});
            end
        end
        @(posedge clk);
        #0.5;
        got = sb.pop_front();
        chk("q1",  {31'b0, q1},  {31'b0, got.q1});
        chk("qn1", {31'b0, qn1}, {31'b0, got.qn1});
        chk("q8",  {24'b0, q8},  {24'b0, got.q8});
        chk("qn8", {24'b0, qn8}, {24'b0, got.qn8});
        last     = got;
        last_vld = 1'b1;
    endtask

    initial begin
        clear = 1'b1;
        d1    = 1'b0;
        d8    = 8'h00;
        @(posedge clk);
        #0.5;

        // clear held, d low, 20 edges
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        // clear held, d toggling
        for (int i = 0; i < 10; i++) cycle(1'b1, i[0], 8'hFF ^ 8'(i), 1'b0);
        // release: first low edge loads d
        cycle(1'b0, 1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h3C, 1'b0);
        // clear asserted mid-cycle: q must hold until the edge
        cycle(1'b1, 1'b1, 8'h3C, 1'b0);
        // glitches between edges are not captured
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h5A, 1'b1);
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        // random traffic
        for (int i = 0; i < 40; i++)
            cycle(($urandom_range(0, 4) == 0), 1'($urandom), 8'($urandom), 1'($urandom));

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
